// File: rtl/wakeup_arbiter.sv
// -----------------------------------------------------------------------------
// wakeup_arbiter
//
// Shares the single wakeup broadcast port of the rename stage between several
// completing functional units. Each requester pushes (physical tag, result)
// pairs into a private circular FIFO. A round-robin arbiter pops at most one
// head per cycle, and the winning entry is driven onto a registered broadcast
// that lasts exactly one cycle.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   req_valid      [NUM_REQ]             requester i presents a completion
//   req_tag        [NUM_REQ*TAG_WIDTH]   requester i tag at [i*TAG_WIDTH +: TAG_WIDTH]
//   req_value      [NUM_REQ*DATA_WIDTH]  requester i result at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      [NUM_REQ]             FIFO i can accept this cycle (registered state only)
//   wakeup_active  broadcast valid this cycle
//   wakeup_tag     broadcast physical tag (0 when idle)
//   wakeup_value   broadcast result value (0 when idle)
// -----------------------------------------------------------------------------
module wakeup_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int TAG_WIDTH   = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_value,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          wakeup_active,
    output logic [TAG_WIDTH-1:0]          wakeup_tag,
    output logic [DATA_WIDTH-1:0]         wakeup_value
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(QUEUE_DEPTH);
    localparam logic [RR_W:0]    NUM_REQ_C = (RR_W + 1)'(NUM_REQ);
    localparam logic [RR_W-1:0]  LAST_REQ  = RR_W'(NUM_REQ - 1);

    // Per-requester FIFO bookkeeping
    logic [CNT_W-1:0] count_q [NUM_REQ];
    logic [CNT_W-1:0] count_d [NUM_REQ];
    logic [PTR_W-1:0] head_q  [NUM_REQ];
    logic [PTR_W-1:0] head_d  [NUM_REQ];
    logic [PTR_W-1:0] tail_q  [NUM_REQ];
    logic [PTR_W-1:0] tail_d  [NUM_REQ];

    // FIFO payload storage
    logic [TAG_WIDTH-1:0]  tag_mem_q   [NUM_REQ][QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] value_mem_q [NUM_REQ][QUEUE_DEPTH];

    logic [RR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic                  wakeup_active_q, wakeup_active_d;
    logic [TAG_WIDTH-1:0]  wakeup_tag_q,    wakeup_tag_d;
    logic [DATA_WIDTH-1:0] wakeup_value_q,  wakeup_value_d;

    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic               grant_valid;
    logic [RR_W-1:0]    grant_idx;
    logic [RR_W:0]      cand_sum;
    logic [RR_W-1:0]    cand_idx;

    // Ready depends only on the registered count, so a requester never sees a
    // combinational path from its own valid or from the current grant.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (count_q[i] < DEPTH_C);
        end
    end

    // Round-robin search starting at rr_ptr_q; first non-empty FIFO wins.
    // Only registered counts are inspected, so an entry written this edge is
    // not eligible until the following cycle.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update so
        // no path leaves it unassigned, which would otherwise infer a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (RR_W + 1)'(k);
            if (cand_sum >= NUM_REQ_C) begin
                cand_sum = cand_sum - NUM_REQ_C;
            end
            cand_idx = cand_sum[RR_W-1:0];
            if (!grant_valid && (count_q[cand_idx] != '0)) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // FIFO pointer and occupancy updates
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            push[i]    = req_valid[i] && req_ready[i];
            pop[i]     = grant_valid && (grant_idx == RR_W'(i));
            count_d[i] = count_q[i];
            head_d[i]  = head_q[i];
            tail_d[i]  = tail_q[i];
            // Depth is a power of two, so pointers wrap by natural overflow.
            if (push[i]) begin
                tail_d[i] = tail_q[i] + PTR_W'(1);
            end
            if (pop[i]) begin
                head_d[i] = head_q[i] + PTR_W'(1);
            end
            if (push[i] && !pop[i]) begin
                count_d[i] = count_q[i] + CNT_W'(1);
            end else if (pop[i] && !push[i]) begin
                count_d[i] = count_q[i] - CNT_W'(1);
            end
        end
    end

    // Pointer advance and broadcast payload selection
    always_comb begin
        rr_ptr_d        = rr_ptr_q;
        wakeup_active_d = grant_valid;
        wakeup_tag_d    = '0;
        wakeup_value_d  = '0;
        if (grant_valid) begin
            rr_ptr_d       = (grant_idx == LAST_REQ) ? '0 : grant_idx + RR_W'(1);
            wakeup_tag_d   = tag_mem_q[grant_idx][head_q[grant_idx]];
            wakeup_value_d = value_mem_q[grant_idx][head_q[grant_idx]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                count_q[i] <= '0;
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
            end
            rr_ptr_q        <= '0;
            wakeup_active_q <= 1'b0;
            wakeup_tag_q    <= '0;
            wakeup_value_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values computed by the always_comb.
            for (int i = 0; i < NUM_REQ; i++) begin
                count_q[i] <= count_d[i];
                head_q[i]  <= head_d[i];
                tail_q[i]  <= tail_d[i];
            end
            rr_ptr_q        <= rr_ptr_d;
            wakeup_active_q <= wakeup_active_d;
            wakeup_tag_q    <= wakeup_tag_d;
            wakeup_value_q  <= wakeup_value_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; a slot is only read
    // after its count says it was written, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                tag_mem_q[i][tail_q[i]]   <= req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                value_mem_q[i][tail_q[i]] <= req_value[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign wakeup_active = wakeup_active_q;
    assign wakeup_tag    = wakeup_tag_q;
    assign wakeup_value  = wakeup_value_q;

endmodule

// File: doc/wakeup_arbiter.md
Name: wakeup_arbiter

Overview:
- Shares the single wakeup broadcast port of the rename stage (wakeup_active / wakeup_tag / wakeup_value) between several completing functional units.
- Each requester pushes completed (physical tag, result) pairs into a private small FIFO.
- A round-robin arbiter pops at most one entry per cycle and drives it onto the registered wakeup broadcast.
- Sits between the execution units' writeback and the rename/issue wakeup inputs.

Parameters:
NUM_REQ, 3, number of completing requesters (ALU, LSU, branch).
TAG_WIDTH, 6, physical register tag width (64 physical regs).
DATA_WIDTH, 32, result value width.
QUEUE_DEPTH, 2, entries per requester FIFO (power of two, >=2).

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  NUM_REQ  bit i: requester i presents a completion.
req_tag  input  NUM_REQ*TAG_WIDTH  requester i tag in bits [i*TAG_WIDTH +: TAG_WIDTH].
req_value  input  NUM_REQ*DATA_WIDTH  requester i result in bits [i*DATA_WIDTH +: DATA_WIDTH].
req_ready  output  NUM_REQ  bit i: FIFO i can accept this cycle.
wakeup_active  output  1  broadcast valid this cycle.
wakeup_tag  output  TAG_WIDTH  broadcast physical tag.
wakeup_value  output  DATA_WIDTH  broadcast result value.

Behaviour:
- Reset:
  - Asserting reset at any time immediately clears all FIFO counts and pointers, rr_ptr=0, wakeup_active=0, wakeup_tag=0, wakeup_value=0.
  - Entries in flight are discarded.
  - req_ready is all ones while reset is asserted and after release.
- Handshake:
  - req_ready[i] = (count_i < QUEUE_DEPTH), driven from registered state only, with no combinational path from req_valid or the current grant.
  - An entry is enqueued at a rising edge when req_valid[i] && req_ready[i].
  - A requester holds valid/tag/value until it sees ready.
- FIFO:
  - Circular buffer, head/tail pointers wrap mod QUEUE_DEPTH.
  - Push and pop of the same FIFO in one cycle leaves count unchanged.
  - Pop of an empty FIFO never occurs.
- Arbitration:
  - Combinational each cycle over FIFOs with count>0 (registered state; an entry pushed this edge is not eligible until the next cycle).
  - Search order is rr_ptr, rr_ptr+1, … mod NUM_REQ; the first non-empty FIFO wins and its head is popped at the edge.
  - After a grant to i, rr_ptr <= (i+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
- Output register:
  - On a grant at edge E, the outputs after E are wakeup_active=1 and the winner head's tag/value.
  - With no grant, wakeup_active=0, wakeup_tag=0, wakeup_value=0.
  - Each broadcast lasts exactly one cycle.
- Latency: push at edge N → broadcast visible after edge N+1 at the earliest (2 edges when uncontended).
- Throughput: one broadcast per cycle. Under continuous load from all requesters, each gets 1 of every NUM_REQ slots.
- Tags are not interpreted. Tag 0 and duplicate tags pass through unchanged, and FIFO order per requester is preserved.
- No internal overflow or underflow is possible. The bench checks that count never exceeds QUEUE_DEPTH.

Test Plan:
- Reset values: assert reset with all req_valid=1 → after release wakeup_active=0, tag=0, value=0, req_ready=3'b111; no broadcast until the cycle after the first push.
- Single requester: req 1 pushes tag=5, value=123 at edge 1, then deasserts → after edge 2 wakeup_active=1, tag=5, value=123; after edge 3 wakeup_active=0, tag=0, value=0.
- Simultaneous requests: reqs 0,1,2 push tags 10,11,12 at the same edge with rr_ptr=0 → broadcasts on 3 consecutive cycles with tags 10,11,12, then wakeup_active=0.
- Round-robin fairness: all three requesters keep pushing every cycle (tags 20+i, 30+i, 40+i) → grants rotate 0,1,2,0,1,2; no requester skipped over 12 cycles.
- Backpressure: req 2 pushes 3 entries (tags 1,2,3) while reqs 0 and 1 saturate arbitration → req_ready[2]=0 after 2 unpopped entries, third push waits, and all three tags appear in order 1,2,3.
- Async reset mid-operation: with 2 entries queued in each FIFO and wakeup_active=1, pulse reset between edges → outputs go to 0 immediately, no stale tags broadcast afterwards, and a new push of tag 7, value 9 broadcasts 2 edges later.
